int_writeback: RTL and testbench

INT_WRITEBACK -- requirements
Module: int_writeback

---
 rtl/int_writeback.sv | 111 +++++++++++
 tb/tb_int_writeback.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_writeback.sv
// Integer writeback queue: merges ALU and load results into a small in-order
// FIFO and drains one entry per cycle into the register-file write port.
module int_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       alu_valid,
  input  logic [4:0]                 alu_addr,
  input  logic [63:0]                alu_data,
  output logic                       alu_ready,
  input  logic                       mem_valid,
  input  logic [4:0]                 mem_addr,
  input  logic [63:0]                mem_data,
  output logic                       mem_ready,
  input  logic                       wb_stall,
  output logic                       write_enable,
  output logic [4:0]                 write_addr,
  output logic [63:0]                write_data,
  input  logic [4:0]                 check_addr_a,
  input  logic [4:0]                 check_addr_b,
  output logic                       busy_a,
  output logic                       busy_b,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]       addr_mem [DEPTH];
  logic [63:0]      data_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic             space;
  logic             mem_fire;
  logic             alu_fire;
  logic [4:0]       push_addr;
  logic [63:0]      push_data;
  logic             push;
  logic             pop;

  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] hit_a;
  logic [DEPTH-1:0] hit_b;

  // Readies are forced low while reset is held so no offer looks accepted.
  assign space     = count_reg < CNT_W'(DEPTH);
  assign mem_ready = reset & space;
  assign alu_ready = reset & space & ~mem_valid;

  assign mem_fire  = mem_valid & mem_ready;
  assign alu_fire  = alu_valid & alu_ready;
  assign push_addr = mem_fire ? mem_addr : alu_addr;
  assign push_data = mem_fire ? mem_data : alu_data;
  // Writes to x0 complete the handshake but never occupy a slot.
  assign push      = (mem_fire | alu_fire) & (push_addr != 5'd0);
  assign pop       = (count_reg != '0) & ~wb_stall;

  assign occupancy = count_reg;

  // An entry is live when its distance from the read pointer is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [PTR_W-1:0] offset;
    assign offset    = PTR_W'(gi) - rd_ptr_reg;
    assign live[gi]  = {1'b0, offset} < count_reg;
    assign hit_a[gi] = live[gi] & (addr_mem[gi] == check_addr_a);
    assign hit_b[gi] = live[gi] & (addr_mem[gi] == check_addr_b);
  end

  assign busy_a = reset & (check_addr_a != 5'd0)
                & ((|hit_a) | (write_enable & (write_addr == check_addr_a)));
  assign busy_b = reset & (check_addr_b != 5'd0)
                & ((|hit_b) | (write_enable & (write_addr == check_addr_b)));

  // Payload storage carries no reset; validity comes only from count/pointers.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= push_addr;
      data_mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      write_enable <= 1'b0;
      write_addr   <= 5'd0;
      write_data   <= 64'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        write_addr <= addr_mem[rd_ptr_reg];
        write_data <= data_mem[rd_ptr_reg];
      end
      write_enable <= pop;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_int_writeback.sv
// Self-checking bench for int_writeback: directed scenarios plus a randomized
// run, all compared against a queue-based reference model.
module tb_int_writeback;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_addr = '0;
  logic [63:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_addr = '0;
  logic [63:0] mem_data = '0;
  logic        mem_ready;
  logic        wb_stall = 1'b0;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [63:0] write_data;
  logic [4:0]  check_addr_a = '0;
  logic [4:0]  check_addr_b = '0;
  logic        busy_a;
  logic        busy_b;
  logic [2:0]  occupancy;

  always #5 clock = ~clock;

  int_writeback #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .wb_stall(wb_stall),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .check_addr_a(check_addr_a), .check_addr_b(check_addr_b),
    .busy_a(busy_a), .busy_b(busy_b), .occupancy(occupancy)
  );

  // Reference model: pending writes in acceptance order plus the last write-port drive.
  typedef struct packed {
    logic [4:0]  a;
    logic [63:0] d;
  } ent_t;

  ent_t        q[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_wa = '0;
  logic [63:0] m_wd = '0;
  int          n_vec = 0;
  int          n_err = 0;

  always @(negedge clock) begin
    if (write_enable === 1'b1)
      $display("writeback x%0d <= %h", write_addr, write_data);
  end

  function automatic logic m_mem_ready();
    return reset && (q.size() < DEPTH);
  endfunction

  function automatic logic m_alu_ready();
    return reset && (q.size() < DEPTH) && !mem_valid;
  endfunction

  function automatic logic m_busy(input logic [4:0] ca);
    if (!reset || ca == 5'd0) return 1'b0;
    if (m_we && m_wa == ca) return 1'b1;
    foreach (q[i]) if (q[i].a == ca) return 1'b1;
    return 1'b0;
  endfunction

  // Advance one clock; the model follows the same edge using pre-edge inputs.
  task automatic tick();
    logic        rst_s, pop_now, mem_acc, alu_acc;
    logic [4:0]  ma, aa;
    logic [63:0] md, ad;
    ent_t        e;
    rst_s   = reset;
    pop_now = reset && q.size() > 0 && !wb_stall;
    mem_acc = reset && mem_valid && q.size() < DEPTH;
    alu_acc = reset && alu_valid && !mem_valid && q.size() < DEPTH;
    ma = mem_addr; md = mem_data; aa = alu_addr; ad = alu_data;
    @(posedge clock);
    if (!rst_s) begin
      q.delete();
      m_we = 1'b0; m_wa = '0; m_wd = '0;
    end else begin
      if (pop_now) begin
        e = q.pop_front();
        m_we = 1'b1; m_wa = e.a; m_wd = e.d;
      end else begin
        m_we = 1'b0;
      end
      if (mem_acc && ma != 5'd0) begin
        e.a = ma; e.d = md; q.push_back(e);
      end else if (alu_acc && aa != 5'd0) begin
        e.a = aa; e.d = ad; q.push_back(e);
      end
    end
    @(negedge clock);
  endtask

  task automatic drive_idle();
    alu_valid = 1'b0; mem_valid = 1'b0; wb_stall = 1'b0;
    check_addr_a = '0; check_addr_b = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd9; mem_valid = 1'b0; check_addr_a = 5'd9;
    #1;
    n_vec++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL reset_alu_ready got %b want 0", alu_ready); end
    n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL reset_mem_ready got %b want 0", mem_ready); end
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy_a got %b want 0", busy_a); end
    tick(); tick();
    drive_idle();
    #1;
    n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    n_vec++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL reset_we got %b want 0", write_enable); end
    n_vec++; if (write_addr !== 5'd0) begin n_err++; $display("FAIL reset_waddr got %0d want 0", write_addr); end
    n_vec++; if (write_data !== 64'd0) begin n_err++; $display("FAIL reset_wdata got %h want 0", write_data); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 64'h1234;
    #1;
    n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL single_ready got %b want 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    #1;
    n_vec++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL single_occ got %0d want 1", occupancy); end
    n_vec++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL single_we_early got %b want 0", write_enable); end
    tick();
    #1;
    n_vec++; if (write_enable !== 1'b1) begin n_err++; $display("FAIL single_we got %b want 1", write_enable); end
    n_vec++; if (write_addr !== 5'd5) begin n_err++; $display("FAIL single_waddr got %0d want 5", write_addr); end
    n_vec++; if (write_data !== 64'h1234) begin n_err++; $display("FAIL single_wdata got %h want 1234", write_data); end
    tick();
    #1;
    n_vec++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL single_we_pulse got %b want 0", write_enable); end
    n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL single_occ_end got %0d want 0", occupancy); end
  endtask

  task automatic test_priority();
    logic [4:0] got[$];
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 64'hA3;
    mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 64'hB4;
    #1;
    n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL prio_mem_ready got %b want 1", mem_ready); end
    n_vec++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL prio_alu_blocked got %b want 0", alu_ready); end
    tick();
    mem_valid = 1'b0;
    #1;
    n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL prio_alu_next got %b want 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (write_enable === 1'b1) got.push_back(write_addr);
      tick();
    end
    n_vec++; if (got.size() != 2) begin n_err++; $display("FAIL prio_count got %0d want 2", got.size()); end
    else begin
      n_vec++; if (got[0] !== 5'd4 || got[1] !== 5'd3) begin n_err++; $display("FAIL prio_order got %0d,%0d want 4,3", got[0], got[1]); end
    end
  endtask

  task automatic test_stall();
    logic [4:0] got[$];
    logic       acc;
    wb_stall = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      mem_valid = 1'b1; mem_addr = 5'(k); mem_data = 64'(k * 17);
      #1;
      n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL stall_fill_ready got %b want 1", mem_ready); end
      tick();
    end
    mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 64'h99;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL stall_occ got %0d want 4", occupancy); end
      n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL stall_full_ready got %b want 0", mem_ready); end
      n_vec++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL stall_we got %b want 0", write_enable); end
      tick();
    end
    wb_stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (write_enable === 1'b1) got.push_back(write_addr);
      acc = mem_valid && mem_ready;
      tick();
      if (acc) mem_valid = 1'b0;
    end
    n_vec++; if (got.size() != 5) begin n_err++; $display("FAIL stall_count got %0d want 5", got.size()); end
    else begin
      n_vec++;
      if (got[0] !== 5'd1 || got[1] !== 5'd2 || got[2] !== 5'd3 || got[3] !== 5'd4 || got[4] !== 5'd9) begin
        n_err++;
        $display("FAIL stall_order got %0d,%0d,%0d,%0d,%0d want 1,2,3,4,9", got[0], got[1], got[2], got[3], got[4]);
      end
    end
  endtask

  task automatic test_zero();
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 64'hFFFF;
    #1;
    n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL zero_ready got %b want 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL zero_occ got %0d want 0", occupancy); end
      n_vec++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL zero_we got %b want 0", write_enable); end
      tick();
    end
  endtask

  task automatic test_busy();
    check_addr_a = 5'd7; check_addr_b = 5'd0; wb_stall = 1'b1;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 64'h77;
    #1;
    tick();
    alu_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL busy_queued_a got %b want 1", busy_a); end
      n_vec++; if (busy_b !== 1'b0) begin n_err++; $display("FAIL busy_queued_b got %b want 0", busy_b); end
      tick();
    end
    wb_stall = 1'b0;
    #1;
    n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL busy_release_a got %b want 1", busy_a); end
    tick();
    #1;
    n_vec++; if (write_enable !== 1'b1) begin n_err++; $display("FAIL busy_we got %b want 1", write_enable); end
    n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL busy_writing_a got %b want 1", busy_a); end
    n_vec++; if (busy_b !== 1'b0) begin n_err++; $display("FAIL busy_writing_b got %b want 0", busy_b); end
    tick();
    #1;
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL busy_done_a got %b want 0", busy_a); end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    wb_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mem_valid = 1'b1; mem_addr = 5'(10 + k); mem_data = 64'(100 + k);
      #1;
      tick();
    end
    mem_valid = 1'b0;
    #1;
    n_vec++; if (occupancy !== 3'd3) begin n_err++; $display("FAIL rmid_occ_pre got %0d want 3", occupancy); end
    reset = 1'b0; wb_stall = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL rmid_occ got %0d want 0", occupancy); end
    n_vec++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL rmid_we got %b want 0", write_enable); end
    n_vec++; if (write_addr !== 5'd0) begin n_err++; $display("FAIL rmid_waddr got %0d want 0", write_addr); end
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      n_vec++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL rmid_ghost_we got %b want 0", write_enable); end
    end
    alu_valid = 1'b1; alu_addr = 5'd13; alu_data = 64'hABCD;
    #1;
    tick();
    alu_valid = 1'b0;
    tick();
    #1;
    n_vec++; if (write_enable !== 1'b1) begin n_err++; $display("FAIL rmid_fresh_we got %b want 1", write_enable); end
    n_vec++; if (write_addr !== 5'd13) begin n_err++; $display("FAIL rmid_fresh_waddr got %0d want 13", write_addr); end
    n_vec++; if (write_data !== 64'hABCD) begin n_err++; $display("FAIL rmid_fresh_wdata got %h want abcd", write_data); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 99) != 0);
      mem_valid    = ($urandom_range(0, 9) < 4);
      alu_valid    = ($urandom_range(0, 9) < 5);
      mem_addr     = 5'($urandom_range(0, 7));
      alu_addr     = 5'($urandom_range(0, 7));
      mem_data     = {$urandom, $urandom};
      alu_data     = {$urandom, $urandom};
      wb_stall     = ($urandom_range(0, 9) < 3);
      check_addr_a = 5'($urandom_range(0, 7));
      check_addr_b = 5'($urandom_range(0, 7));
      #1;
      n_vec++; if (mem_ready !== m_mem_ready()) begin n_err++; $display("FAIL rand_mem_ready cyc %0d got %b want %b", i, mem_ready, m_mem_ready()); end
      n_vec++; if (alu_ready !== m_alu_ready()) begin n_err++; $display("FAIL rand_alu_ready cyc %0d got %b want %b", i, alu_ready, m_alu_ready()); end
      n_vec++; if (occupancy !== 3'(q.size())) begin n_err++; $display("FAIL rand_occ cyc %0d got %0d want %0d", i, occupancy, q.size()); end
      n_vec++; if (write_enable !== m_we) begin n_err++; $display("FAIL rand_we cyc %0d got %b want %b", i, write_enable, m_we); end
      n_vec++; if (write_addr !== m_wa) begin n_err++; $display("FAIL rand_waddr cyc %0d got %0d want %0d", i, write_addr, m_wa); end
      n_vec++; if (write_data !== m_wd) begin n_err++; $display("FAIL rand_wdata cyc %0d got %h want %h", i, write_data, m_wd); end
      n_vec++; if (busy_a !== m_busy(check_addr_a)) begin n_err++; $display("FAIL rand_busy_a cyc %0d got %b want %b", i, busy_a, m_busy(check_addr_a)); end
      n_vec++; if (busy_b !== m_busy(check_addr_b)) begin n_err++; $display("FAIL rand_busy_b cyc %0d got %b want %b", i, busy_b, m_busy(check_addr_b)); end
      tick();
    end
    reset = 1'b1;
    drive_idle();
  endtask

  initial begin
    test_reset();
    drive_idle();
    test_single();
    drive_idle();
    test_priority();
    drive_idle();
    test_stall();
    drive_idle();
    test_zero();
    drive_idle();
    test_busy();
    drive_idle();
    test_reset_mid();
    drive_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
